// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM state encoding and default word width.
package spi_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one SPI pin plus rise/fall detection of the
// synchronised level. Flops reset to 1 so idle-high pins produce no edge at
// reset release.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Shift the pin into the chain and keep a one-cycle-delayed copy of the output.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchroniser and delay registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave (clock idles high, mosi/miso change on spi_clk rising, sampled on
// falling). All pins are oversampled in the clk domain; received words appear on
// data_rd with a one-cycle rd_valid pulse, and tx_buf is shifted out on miso.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_clk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] data_tx,
    input  logic                  tx_load,
    output logic [DATA_WIDTH-1:0] data_rd,
    output logic                  rd_valid,
    output logic                  frame_err,
    output logic                  busy,
    output logic [1:0]            state
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(spi_clk),
        .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .reset(reset), .din(cs),
        .level(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(mosi),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic [DATA_WIDTH-1:0] data_rd_q, data_rd_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  miso_q, miso_d;
    logic                  skip_rise_q, skip_rise_d;

    // Next-state logic: frame start, bit shifting, word boundaries and frame end.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        tx_buf_d    = tx_load ? data_tx : tx_buf_q;
        data_rd_d   = data_rd_q;
        rd_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        miso_d      = miso_q;
        skip_rise_d = skip_rise_q;

        case (state_q)
            IDLE: begin
                miso_d  = 1'b1;
                count_d = CNT_FULL;
                if (cs_fall) begin
                    // MSB is presented now and consumed by the first falling
                    // edge, so the first rising edge of the frame must shift.
                    state_d     = SHIFT;
                    tx_shift_d  = tx_buf_d;
                    miso_d      = tx_buf_d[DATA_WIDTH-1];
                    skip_rise_d = 1'b0;
                end
            end
            SHIFT: begin
                if (sclk_fall) begin
                    rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (count_q == CNT_ONE) begin
                        // Word complete: publish it and reload for the next word.
                        // The reload presents the new MSB before the rising edge
                        // that follows, so that rising edge must not shift.
                        data_rd_d   = rx_shift_d;
                        rd_valid_d  = 1'b1;
                        count_d     = CNT_FULL;
                        tx_shift_d  = tx_buf_d;
                        miso_d      = tx_buf_d[DATA_WIDTH-1];
                        skip_rise_d = 1'b1;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end
                if (sclk_rise) begin
                    if (skip_rise_q) begin
                        skip_rise_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        miso_d     = tx_shift_q[DATA_WIDTH-2];
                    end
                end
                if (cs_rise) begin
                    // A word finishing in this same cycle has already reset count_d.
                    state_d     = IDLE;
                    miso_d      = 1'b1;
                    frame_err_d = (count_d != CNT_FULL);
                    count_d     = CNT_FULL;
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b1;
                count_d = CNT_FULL;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= CNT_FULL;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            data_rd_q   <= '0;
            rd_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b1;
            skip_rise_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            data_rd_q   <= data_rd_d;
            rd_valid_q  <= rd_valid_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
            skip_rise_q <= skip_rise_d;
        end
    end

    assign miso      = miso_q;
    assign data_rd   = data_rd_q;
    assign rd_valid  = rd_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == SHIFT);
    assign state     = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a table of directed frames, randomized
// frames checked against a word-level model, and a mid-frame reset sequence.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_clk, cs, mosi;
    logic       miso;
    logic [7:0] data_tx;
    logic       tx_load;
    logic [7:0] data_rd;
    logic       rd_valid, frame_err, busy;
    logic [1:0] state;

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .cs(cs), .mosi(mosi),
        .miso(miso), .data_tx(data_tx), .tx_load(tx_load), .data_rd(data_rd),
        .rd_valid(rd_valid), .frame_err(frame_err), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nbits;
        logic [15:0] mosi;      // bit i of the frame is mosi[15-i]
        logic [7:0]  tx0;       // loaded before cs falls
        logic [7:0]  tx1;       // loaded during the first word when load1
        bit          load1;
        bit          cs_at_fall; // cs rises together with the last falling edge
        int          exp_words;
        logic [7:0]  exp_w0;
        logic [7:0]  exp_w1;
        int          exp_err;
        logic [15:0] exp_miso;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    int         err_cnt;
    logic [7:0] rd_q[$];
    logic [7:0] last_word;
    vec_t       tbl[6];

    // Capture every rd_valid cycle and every frame_err cycle.
    always @(negedge clk) begin
        if (rd_valid) rd_q.push_back(data_rd);
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Wait half an SPI period (8 clk), optionally pulsing tx_load in the first cycle.
    task automatic half(input bit ld, input logic [7:0] d);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ld && k == 0) begin
                data_tx = d;
                tx_load = 1'b1;
            end else begin
                tx_load = 1'b0;
            end
        end
    endtask

    // Word-level reference: whole bytes are received, leftovers are an error,
    // and miso carries tx0 then whatever tx_buf held at the word boundary.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_words = v.nbits / 8;
        r.exp_w0    = v.mosi[15:8];
        r.exp_w1    = v.mosi[7:0];
        r.exp_err   = ((v.nbits % 8) != 0) ? 1 : 0;
        r.exp_miso  = {v.tx0, (v.load1 ? v.tx1 : v.tx0)};
        return r;
    endfunction

    task automatic run_frame(input int idx, input vec_t v);
        logic [15:0] got_miso = '0;
        logic [15:0] mask;
        half(1'b1, v.tx0);
        rd_q.delete();
        err_cnt = 0;
        chk("miso_idle", {31'd0, miso}, 32'd1);
        mosi = v.mosi[15];
        cs   = 1'b0;
        half(1'b0, 8'h00);
        chk("busy_shift", {31'd0, busy}, 32'd1);
        for (int i = 0; i < v.nbits; i++) begin
            got_miso[15-i] = miso;
            spi_clk = 1'b0;
            if (i == v.nbits - 1 && v.cs_at_fall) cs = 1'b1;
            half(1'b0, 8'h00);
            if (i == v.nbits - 1 && v.cs_at_fall) break;
            spi_clk = 1'b1;
            if (i < 15) mosi = v.mosi[14-i];
            half(i == 3 && v.load1, v.tx1);
        end
        cs = 1'b1;
        repeat (12) @(negedge clk);
        spi_clk = 1'b1;
        repeat (4) @(negedge clk);

        mask = 16'hFFFF << (16 - v.nbits);
        chk("miso_bits", {16'd0, got_miso & mask}, {16'd0, v.exp_miso & mask});
        chk("rd_count", rd_q.size(), v.exp_words);
        for (int k = 0; k < v.exp_words && k < rd_q.size(); k++)
            chk("rd_word", {24'd0, rd_q[k]}, {24'd0, (k == 0) ? v.exp_w0 : v.exp_w1});
        if (v.exp_words == 1) last_word = v.exp_w0;
        if (v.exp_words == 2) last_word = v.exp_w1;
        chk("data_rd_hold", {24'd0, data_rd}, {24'd0, last_word});
        chk("frame_err", err_cnt, v.exp_err);
        chk("state_idle", {30'd0, state}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("miso_after", {31'd0, miso}, 32'd1);
        $display("frame %0d: bits=%0d mosi=%h tx=%h/%h rd_pulses=%0d data_rd=%h frame_err_cycles=%0d",
                 idx, v.nbits, v.mosi, v.tx0, v.tx1, rd_q.size(), data_rd, err_cnt);
    endtask

    initial begin
        vec_t v;
        //         bits  mosi      tx0    tx1    ld  caf  words  w0     w1     err  miso
        tbl[0] = '{8,  16'hA500, 8'h3C, 8'h00, 0, 0, 1, 8'hA5, 8'h00, 0, 16'h3C3C};
        tbl[1] = '{16, 16'h1234, 8'h9A, 8'h56, 1, 0, 2, 8'h12, 8'h34, 0, 16'h9A56};
        tbl[2] = '{5,  16'hB000, 8'h0F, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 16'h0F0F};
        tbl[3] = '{8,  16'hFF00, 8'hC3, 8'h00, 0, 0, 1, 8'hFF, 8'h00, 0, 16'hC3C3};
        tbl[4] = '{8,  16'h6E00, 8'h01, 8'h00, 0, 1, 1, 8'h6E, 8'h00, 0, 16'h0101};
        tbl[5] = '{16, 16'hBEEF, 8'h55, 8'hAA, 1, 1, 2, 8'hBE, 8'hEF, 0, 16'h55AA};

        reset   = 1'b1;
        spi_clk = 1'b1;
        cs      = 1'b1;
        mosi    = 1'b1;
        data_tx = 8'h00;
        tx_load = 1'b0;
        err_cnt = 0;
        last_word = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_miso", {31'd0, miso}, 32'd1);
        chk("rst_data_rd", {24'd0, data_rd}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int t = 0; t < 6; t++) run_frame(t, tbl[t]);

        for (int t = 0; t < 20; t++) begin
            v.nbits      = $urandom_range(1, 16);
            v.mosi       = 16'($urandom);
            v.tx0        = 8'($urandom);
            v.tx1        = 8'($urandom);
            v.load1      = 1'($urandom);
            v.cs_at_fall = ((v.nbits % 8) == 0) ? 1'($urandom) : 1'b0;
            run_frame(100 + t, model(v));
        end

        // Reset in the middle of a frame, after four bits.
        half(1'b1, 8'hE7);
        mosi = 1'b1;
        cs   = 1'b0;
        half(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            spi_clk = 1'b0;
            half(1'b0, 8'h00);
            spi_clk = 1'b1;
            mosi    = ~mosi;
            half(1'b0, 8'h00);
        end
        #2 reset = 1'b1;
        #1;
        chk("midrst_miso", {31'd0, miso}, 32'd1);
        chk("midrst_data_rd", {24'd0, data_rd}, 32'd0);
        chk("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_state", {30'd0, state}, 32'd0);
        $display("reset mid-frame: state=%0d busy=%0b miso=%0b data_rd=%h", state, busy, miso, data_rd);
        last_word = 8'h00;
        cs = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        v = '{8, 16'h8100, 8'h5A, 8'h00, 0, 0, 1, 8'h81, 8'h00, 0, 16'h5A5A};
        run_frame(200, v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
